// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-look-ahead adder: pipeline geometry
// derived from the parameters, a parameter sanity check, and the result-flag bundle.
package cla_pkg;

  function automatic int cla_stage_bits(input int block, input int stage_blocks);
    return block * stage_blocks;
  endfunction

  function automatic int cla_groups_per_stage(input int stage_blocks);
    return stage_blocks;
  endfunction

  function automatic int cla_nstage(input int width, input int block, input int stage_blocks);
    return width / (block * stage_blocks);
  endfunction

  function automatic bit cla_params_ok(input int width, input int block, input int stage_blocks);
    return (width > 0) && (block > 0) && (stage_blocks > 0) &&
           (width % block == 0) && (width % (block * stage_blocks) == 0);
  endfunction

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } cla_flags_t;

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-look-ahead group.
// Group P/G depend only on a and b, never on cin.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in,
  output logic             grp_p,
  output logic             grp_g
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Kept apart from the carry process so the top can chain groups without a
  // cin -> grp_p dependency.
  always_comb begin
    grp_p = &p;
    grp_g = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      grp_g = g[i] | (p[i] & grp_g);
    end
  end

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum      = p ^ c[BLOCK-1:0];
    cout     = c[BLOCK];
    c_msb_in = c[BLOCK-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor with valid/ready on both sides.
// Each stage resolves STAGE_BLOCKS groups; carries cross stage boundaries through registers.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BLOCK        = 4,
  parameter int STAGE_BLOCKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SBITS  = cla_stage_bits(BLOCK, STAGE_BLOCKS);
  localparam int GPS    = cla_groups_per_stage(STAGE_BLOCKS);
  localparam int NSTAGE = cla_nstage(WIDTH, BLOCK, STAGE_BLOCKS);

  if (!cla_params_ok(WIDTH, BLOCK, STAGE_BLOCKS)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK*STAGE_BLOCKS");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
    logic             carry;
  } stage_t;

  stage_t [NSTAGE-1:0] q_all;
  stage_t [NSTAGE-1:0] nxt_all;
  logic   [NSTAGE-1:0] msb_in_all;
  stage_t              prep;
  stage_t              last;
  cla_flags_t          flags;
  logic                advance;
  logic                unused_top;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Subtraction as A + ~B + ~cin, so cout=1 reads as "no borrow".
  always_comb begin
    prep.valid    = in_valid;
    prep.a_rem    = in_a;
    prep.b_rem    = in_sub ? ~in_b : in_b;
    prep.sum_done = '0;
    prep.carry    = in_sub ? ~in_cin : in_cin;
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t           q;
    stage_t           nxt;
    logic [GPS:0]     c;
    logic [GPS-1:0]   gp;
    logic [GPS-1:0]   gg;
    logic [GPS-1:0]   gcout;
    logic [GPS-1:0]   gmsb;
    logic [SBITS-1:0] ssum;
    logic             unused_grp;

    assign q = q_all[k];

    for (genvar g = 0; g < GPS; g++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a        (q.a_rem[k*SBITS + g*BLOCK +: BLOCK]),
        .b        (q.b_rem[k*SBITS + g*BLOCK +: BLOCK]),
        .cin      (c[g]),
        .sum      (ssum[g*BLOCK +: BLOCK]),
        .cout     (gcout[g]),
        .c_msb_in (gmsb[g]),
        .grp_p    (gp[g]),
        .grp_g    (gg[g])
      );
    end

    always_comb begin
      c    = '0;
      c[0] = q.carry;
      for (int i = 0; i < GPS; i++) begin
        c[i+1] = gg[i] | (gp[i] & c[i]);
      end
    end

    always_comb begin
      nxt                             = q;
      nxt.sum_done[k*SBITS +: SBITS]  = ssum;
      nxt.carry                       = c[GPS];
    end

    assign nxt_all[k]    = nxt;
    assign msb_in_all[k] = gmsb[GPS-1];
    assign unused_grp    = ^{gcout, gmsb};
  end

  assign last = nxt_all[NSTAGE-1];

  always_comb begin
    flags.cout = last.carry;
    flags.ovf  = msb_in_all[NSTAGE-1] ^ last.carry;
    flags.zero = ~|last.sum_done;
  end

  assign unused_top = ^{last.a_rem, last.b_rem, msb_in_all};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_all     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (advance) begin
      q_all[0] <= prep;
      for (int k = 1; k < NSTAGE; k++) begin
        q_all[k] <= nxt_all[k-1];
      end
      out_valid <= last.valid;
      // Result fields hold their last value across bubbles.
      if (last.valid) begin
        out_sum  <= last.sum_done;
        out_cout <= flags.cout;
        out_ovf  <= flags.ovf;
        out_zero <= flags.zero;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes model results, monitor pops
// and compares whenever a result beat transfers.
module tb_cla_pipe_adder;

  localparam int W      = 32;
  localparam int NSTAGE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;
  logic [W-1:0] out_sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc_cyc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_out   = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGE_BLOCKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, c, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = longint'(cin);
    if (!sub) begin
      ur     = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = (ur >= (longint'(1) <<< 32));
    end else begin
      ur     = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (ua >= ub + c);
    end
    e.sum     = ur[W-1:0];
    e.ovf     = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.zero    = (e.sum == '0);
    e.acc_cyc = 0;
    e.lat     = 1'b0;
    return e;
  endfunction

  task automatic step_drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic ordy,
                            input bit lat, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e         = model(a, b, cin, sub);
      e.acc_cyc = cyc + 1;
      e.lat     = lat;
      q.push_back(e);
      n_acc++;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit acc;
    int tries = 0;
    do begin
      step_drive(1'b1, a, b, cin, sub, 1'b1, 1'b1, acc);
      tries++;
    end while (!acc && tries < 20);
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_empty();
    bit acc;
    int i = 0;
    while (q.size() != 0 && i < 200) begin
      step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      i++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: out_sum=%0h while scoreboard is empty", out_sum);
      end else begin
        mon_e = q.pop_front();
        n_out++;
        check("sum", out_sum, mon_e.sum);
        check("cout", out_cout, mon_e.cout);
        check("ovf", out_ovf, mon_e.ovf);
        check("zero", out_zero, mon_e.zero);
        if (mon_e.lat) check("latency", cyc - mon_e.acc_cyc, NSTAGE);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    bit           acc;
    int           fill;
    int           guard;
    int           n_rand;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed corner cases, back to back
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    wait_empty();

    // Randomised traffic with random valid and backpressure
    n_rand = 0;
    guard  = 0;
    while (n_rand < 1000 && guard < 20000) begin
      step_drive($urandom_range(0, 9) < 7, pick_operand(), pick_operand(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, 1'b0, acc);
      if (acc) n_rand++;
      guard++;
    end
    check("random_beats_accepted", n_rand, 1000);
    wait_empty();

    // Fill the pipe under backpressure, hold, then drain
    fill  = 0;
    guard = 0;
    do begin
      step_drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
      if (acc) fill++;
      guard++;
    end while (acc && guard < 20);
    check("fill_count", fill, NSTAGE + 1);
    for (int i = 0; i < 10; i++) begin
      step_drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      check("stall_accept", acc, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_sum", out_sum, q[0].sum);
      check("stall_out_flags", {out_cout, out_ovf, out_zero}, {q[0].cout, q[0].ovf, q[0].zero});
    end
    for (int i = 0; i < fill; i++) begin
      step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      check("drain_consecutive", out_valid, 1);
    end
    step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("drain_done", out_valid, 0);
    check("drain_queue", q.size(), 0);

    // Asynchronous reset with beats in flight
    for (int i = 0; i < 4; i++) begin
      step_drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, acc);
      check("rst_seq_accept", acc, 1);
    end
    guard = 0;
    do begin
      step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      guard++;
    end while (!out_valid && guard < 10);
    check("pre_rst_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    n_acc -= q.size();
    q.delete();
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", out_sum, 0);
    check("async_rst_zero", out_zero, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      check("post_rst_idle", out_valid, 0);
    end
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    wait_empty();

    check("in_out_count", n_out, n_acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
